// File: rtl/weight_s_loader_wq_weight_s_sum_mmap_m_axi_load_pkg.sv
// Shared definitions for the m_axi load stage: default bus geometry, log2 helper and
// the chunk-issue FSM encoding.
package weight_s_loader_wq_weight_s_sum_mmap_m_axi_load_pkg;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned log2(input int unsigned x);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned BUS_DATA_BYTES = 4;
  localparam int unsigned BUS_ADDR_ALIGN = log2(BUS_DATA_BYTES);

  typedef enum logic [0:0] {
    StIdle,
    StLoad
  } load_state_e;

endpackage

// File: rtl/weight_s_loader_wq_weight_s_sum_mmap_m_axi_fifo.sv
// First-word-fall-through synchronous FIFO; push when full and pop when empty are ignored.
module weight_s_loader_wq_weight_s_sum_mmap_m_axi_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_push = en_i && push_i && !full_o;
  assign do_pop  = en_i && pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/weight_s_loader_wq_weight_s_sum_mmap_m_axi_load.sv
// User-facing load stage: splits user reads into credit-gated chunks, buffers returned beats
// and presents them as a stream with a per-request last flag.
module weight_s_loader_wq_weight_s_sum_mmap_m_axi_load
  import weight_s_loader_wq_weight_s_sum_mmap_m_axi_load_pkg::*;
#(
  parameter int unsigned BUS_ADDR_WIDTH        = 32,
  parameter int unsigned BUS_DATA_WIDTH        = BUS_DATA_BYTES * 8,
  parameter int unsigned MAX_READ_BURST_LENGTH = 16,
  parameter int unsigned USER_MAXREQS          = 4,
  parameter int unsigned BUFFER_DEPTH          = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      ACLK_EN,
  input  logic [BUS_ADDR_WIDTH-1:0] in_USER_ARADDR,
  input  logic [31:0]               in_USER_ARLEN,
  input  logic                      in_USER_ARVALID,
  output logic                      out_USER_ARREADY,
  output logic [BUS_DATA_WIDTH-1:0] out_USER_RDATA,
  output logic                      out_USER_RLAST,
  output logic                      out_USER_RVALID,
  input  logic                      in_USER_RREADY,
  output logic [BUS_ADDR_WIDTH-1:0] out_HLS_ARADDR,
  output logic [31:0]               out_HLS_ARLEN,
  output logic                      out_HLS_ARVALID,
  input  logic                      in_HLS_ARREADY,
  input  logic [BUS_DATA_WIDTH-1:0] in_HLS_RDATA,
  input  logic [1:0]                in_HLS_RLAST,
  input  logic                      in_HLS_RVALID,
  output logic                      out_HLS_RREADY,
  output logic                      out_HLS_RBUST_READY
);

  localparam int unsigned AddrAlign = (BUS_DATA_WIDTH == BUS_DATA_BYTES * 8) ?
                                      BUS_ADDR_ALIGN : log2(BUS_DATA_WIDTH / 8);
  localparam int unsigned CreditW   = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned ReqW      = BUS_ADDR_WIDTH + 32;
  localparam logic [BUS_ADDR_WIDTH-1:0] AlignMask =
      ~BUS_ADDR_WIDTH'((64'd1 << AddrAlign) - 64'd1);

  load_state_e               state_q;
  logic [BUS_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               rem_q;
  logic [CreditW-1:0]        credit_q;
  logic                      rbust_q;

  logic [ReqW-1:0]           req_wdata, req_rdata;
  logic                      req_empty, req_full, req_pop;
  logic                      tag_head, tag_empty, tag_full, tag_pop;
  logic [BUS_DATA_WIDTH:0]   data_wdata, data_rdata;
  logic                      data_empty, data_full;
  logic [31:0]               chunk;
  logic                      issue, user_pop, hls_beat;

  assign req_wdata = {in_USER_ARADDR & AlignMask, in_USER_ARLEN};
  assign req_pop   = (state_q == StIdle) && !req_empty;

  weight_s_loader_wq_weight_s_sum_mmap_m_axi_fifo #(
    .Width (ReqW),
    .Depth (USER_MAXREQS)
  ) u_req_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .en_i    (ACLK_EN),
    .push_i  (in_USER_ARVALID),
    .wdata_i (req_wdata),
    .pop_i   (req_pop),
    .rdata_o (req_rdata),
    .empty_o (req_empty),
    .full_o  (req_full)
  );

  assign chunk = (rem_q > MAX_READ_BURST_LENGTH) ? 32'(MAX_READ_BURST_LENGTH) : rem_q;

  // ARVALID only rises once the whole chunk fits in the buffer, so it cannot drop unaccepted.
  assign out_HLS_ARVALID = (state_q == StLoad) && (rem_q != '0) && (32'(credit_q) >= chunk);
  assign out_HLS_ARADDR  = addr_q;
  assign out_HLS_ARLEN   = chunk;
  assign issue           = out_HLS_ARVALID && in_HLS_ARREADY;

  // One tag per issued chunk: marks whether its last beat ends the user request.
  weight_s_loader_wq_weight_s_sum_mmap_m_axi_fifo #(
    .Width (1),
    .Depth (BUFFER_DEPTH)
  ) u_tag_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .en_i    (ACLK_EN),
    .push_i  (issue && !tag_full),
    .wdata_i (rem_q == chunk),
    .pop_i   (tag_pop),
    .rdata_o (tag_head),
    .empty_o (tag_empty),
    .full_o  (tag_full)
  );

  assign hls_beat       = in_HLS_RVALID && !data_full;
  assign tag_pop        = hls_beat && in_HLS_RLAST[1];
  assign data_wdata     = {in_HLS_RLAST[1] && tag_head && !tag_empty, in_HLS_RDATA};
  assign user_pop       = !data_empty && in_USER_RREADY;
  assign out_HLS_RREADY = !data_full;

  weight_s_loader_wq_weight_s_sum_mmap_m_axi_fifo #(
    .Width (BUS_DATA_WIDTH + 1),
    .Depth (BUFFER_DEPTH)
  ) u_data_fifo (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .en_i    (ACLK_EN),
    .push_i  (hls_beat),
    .wdata_i (data_wdata),
    .pop_i   (user_pop),
    .rdata_o (data_rdata),
    .empty_o (data_empty),
    .full_o  (data_full)
  );

  assign out_USER_ARREADY    = !req_full;
  assign out_USER_RDATA      = data_rdata[BUS_DATA_WIDTH-1:0];
  assign out_USER_RLAST      = data_rdata[BUS_DATA_WIDTH];
  assign out_USER_RVALID     = !data_empty;
  assign out_HLS_RBUST_READY = rbust_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
    end else if (ACLK_EN) begin
      case (state_q)
        StIdle: begin
          if (!req_empty) begin
            addr_q  <= req_rdata[ReqW-1:32];
            rem_q   <= req_rdata[31:0];
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (rem_q == '0) begin
            state_q <= StIdle;
          end else if (issue) begin
            addr_q <= addr_q + (BUS_ADDR_WIDTH'(chunk) << AddrAlign);
            rem_q  <= rem_q - chunk;
            if (rem_q == chunk) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      credit_q <= CreditW'(BUFFER_DEPTH);
      rbust_q  <= 1'b0;
    end else if (ACLK_EN) begin
      credit_q <= credit_q - (issue ? CreditW'(chunk) : CreditW'(0))
                           + (user_pop ? CreditW'(1) : CreditW'(0));
      rbust_q  <= hls_beat && in_HLS_RLAST[0];
    end
  end

endmodule

// File: tb/tb_weight_s_loader_wq_weight_s_sum_mmap_m_axi_load.sv
// Directed bench for the m_axi load stage with a simple read-stage responder model.
module tb_weight_s_loader_wq_weight_s_sum_mmap_m_axi_load;

  logic        ACLK, ARESET, ACLK_EN;
  logic [31:0] in_USER_ARADDR, in_USER_ARLEN;
  logic        in_USER_ARVALID, out_USER_ARREADY;
  logic [31:0] out_USER_RDATA;
  logic        out_USER_RLAST, out_USER_RVALID, in_USER_RREADY;
  logic [31:0] out_HLS_ARADDR, out_HLS_ARLEN;
  logic        out_HLS_ARVALID, in_HLS_ARREADY;
  logic [31:0] in_HLS_RDATA;
  logic [1:0]  in_HLS_RLAST;
  logic        in_HLS_RVALID, out_HLS_RREADY, out_HLS_RBUST_READY;

  weight_s_loader_wq_weight_s_sum_mmap_m_axi_load dut (
    .ACLK                (ACLK),
    .ARESET              (ARESET),
    .ACLK_EN             (ACLK_EN),
    .in_USER_ARADDR      (in_USER_ARADDR),
    .in_USER_ARLEN       (in_USER_ARLEN),
    .in_USER_ARVALID     (in_USER_ARVALID),
    .out_USER_ARREADY    (out_USER_ARREADY),
    .out_USER_RDATA      (out_USER_RDATA),
    .out_USER_RLAST      (out_USER_RLAST),
    .out_USER_RVALID     (out_USER_RVALID),
    .in_USER_RREADY      (in_USER_RREADY),
    .out_HLS_ARADDR      (out_HLS_ARADDR),
    .out_HLS_ARLEN       (out_HLS_ARLEN),
    .out_HLS_ARVALID     (out_HLS_ARVALID),
    .in_HLS_ARREADY      (in_HLS_ARREADY),
    .in_HLS_RDATA        (in_HLS_RDATA),
    .in_HLS_RLAST        (in_HLS_RLAST),
    .in_HLS_RVALID       (in_HLS_RVALID),
    .out_HLS_RREADY      (out_HLS_RREADY),
    .out_HLS_RBUST_READY (out_HLS_RBUST_READY)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] iss_addr[$];
  logic [31:0] iss_len[$];
  logic [31:0] pend_addr[$];
  logic [31:0] pend_len[$];
  int unsigned beat_idx = 0;
  int          r_count  = 0;
  bit          auto_r   = 1'b1;
  bit          flush    = 1'b0;
  bit          ar_hs, r_hs;
  logic [31:0] cap_a, cap_l;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Read-stage model: logs every accepted chunk and returns its beats, data = beat address.
  initial begin
    in_HLS_RVALID = 1'b0;
    in_HLS_RDATA  = '0;
    in_HLS_RLAST  = 2'b00;
    forever begin
      @(negedge ACLK);
      ar_hs = out_HLS_ARVALID && in_HLS_ARREADY && ACLK_EN && !ARESET;
      r_hs  = in_HLS_RVALID && out_HLS_RREADY && ACLK_EN && !ARESET && auto_r;
      cap_a = out_HLS_ARADDR;
      cap_l = out_HLS_ARLEN;
      @(posedge ACLK);
      #1;
      if (flush) begin
        pend_addr.delete();
        pend_len.delete();
        beat_idx      = 0;
        flush         = 1'b0;
        in_HLS_RVALID = 1'b0;
      end else begin
        if (r_hs) begin
          r_count++;
          beat_idx++;
          if (beat_idx == pend_len[0]) begin
            void'(pend_addr.pop_front());
            void'(pend_len.pop_front());
            beat_idx = 0;
          end
        end
        if (ar_hs) begin
          iss_addr.push_back(cap_a);
          iss_len.push_back(cap_l);
          if (auto_r) begin
            pend_addr.push_back(cap_a);
            pend_len.push_back(cap_l);
          end
        end
        if (auto_r) begin
          if (pend_addr.size() > 0) begin
            in_HLS_RVALID   = 1'b1;
            in_HLS_RDATA    = pend_addr[0] + 32'(4 * beat_idx);
            in_HLS_RLAST[1] = (beat_idx == pend_len[0] - 1);
            in_HLS_RLAST[0] = (beat_idx == pend_len[0] - 1) || (beat_idx % 8 == 7);
          end else begin
            in_HLS_RVALID = 1'b0;
            in_HLS_RLAST  = 2'b00;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic push_req(input logic [31:0] addr, input logic [31:0] len);
    int k;
    in_USER_ARADDR  = addr;
    in_USER_ARLEN   = len;
    in_USER_ARVALID = 1'b1;
    k = 0;
    while (!out_USER_ARREADY && k < 50) begin
      tick();
      k++;
    end
    chk("req_accept_wait", 64'(k < 50), 64'd1);
    tick();
    in_USER_ARVALID = 1'b0;
  endtask

  task automatic wait_issued(input int target, input int budget);
    int k;
    k = 0;
    while (iss_addr.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk("chunk_issue_wait", 64'(iss_addr.size()), 64'(target));
  endtask

  // Consume beats first..total-1 of a request whose beat n carries data base+4n.
  task automatic drain(input string tag, input logic [31:0] base, input int first,
                       input int total, input int budget);
    int n, k;
    in_USER_RREADY = 1'b1;
    n = first;
    k = 0;
    while (n < total && k < budget) begin
      if (out_USER_RVALID) begin
        chk({tag, "_data"}, 64'(out_USER_RDATA), 64'(base + 32'(4 * n)));
        chk({tag, "_last"}, 64'(out_USER_RLAST), 64'(n == total - 1));
        n++;
      end
      tick();
      k++;
    end
    chk({tag, "_count"}, 64'(n), 64'(total));
  endtask

  initial begin
    int c0, k;
    ARESET          = 1'b1;
    ACLK_EN         = 1'b1;
    in_USER_ARADDR  = '0;
    in_USER_ARLEN   = '0;
    in_USER_ARVALID = 1'b0;
    in_USER_RREADY  = 1'b1;
    in_HLS_ARREADY  = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0;
    tick();

    // Reset state
    chk("rst_arvalid", 64'(out_HLS_ARVALID), 64'd0);
    chk("rst_rvalid", 64'(out_USER_RVALID), 64'd0);
    chk("rst_rbust", 64'(out_HLS_RBUST_READY), 64'd0);
    chk("rst_arready", 64'(out_USER_ARREADY), 64'd1);
    chk("rst_hls_rready", 64'(out_HLS_RREADY), 64'd1);
    chk("rst_credit", 64'(dut.credit_q), 64'd32);

    // 40-beat request splits into 16/16/8
    push_req(32'h1000, 32'd40);
    drain("t1", 32'h1000, 0, 40, 200);
    chk("t1_nchunks", 64'(iss_addr.size()), 64'd3);
    chk("t1_c0_addr", 64'(iss_addr[0]), 64'h1000);
    chk("t1_c0_len", 64'(iss_len[0]), 64'd16);
    chk("t1_c1_addr", 64'(iss_addr[1]), 64'h1040);
    chk("t1_c1_len", 64'(iss_len[1]), 64'd16);
    chk("t1_c2_addr", 64'(iss_addr[2]), 64'h1080);
    chk("t1_c2_len", 64'(iss_len[2]), 64'd8);

    // Zero-length request then a misaligned single-beat request
    c0 = iss_addr.size();
    push_req(32'h5000, 32'd0);
    push_req(32'h6006, 32'd1);
    drain("t2", 32'h6004, 0, 1, 50);
    repeat (5) tick();
    chk("t2_nchunks", 64'(iss_addr.size() - c0), 64'd1);
    chk("t2_addr", 64'(iss_addr[c0]), 64'h6004);
    chk("t2_len", 64'(iss_len[c0]), 64'd1);

    // Burst-ready pulse, driven by hand
    auto_r         = 1'b0;
    in_USER_RREADY = 1'b0;
    c0             = iss_addr.size();
    push_req(32'h7000, 32'd2);
    wait_issued(c0 + 1, 20);
    chk("t5_len", 64'(iss_len[c0]), 64'd2);
    in_HLS_RDATA  = 32'h7000;
    in_HLS_RLAST  = 2'b01;
    in_HLS_RVALID = 1'b1;
    tick();
    in_HLS_RVALID = 1'b0;
    in_HLS_RLAST  = 2'b00;
    chk("t5_rbust_pulse", 64'(out_HLS_RBUST_READY), 64'd1);
    chk("t5_rvalid_next", 64'(out_USER_RVALID), 64'd1);
    tick();
    chk("t5_rbust_clear", 64'(out_HLS_RBUST_READY), 64'd0);
    in_HLS_RDATA  = 32'h7004;
    in_HLS_RLAST  = 2'b11;
    in_HLS_RVALID = 1'b1;
    tick();
    in_HLS_RVALID = 1'b0;
    in_HLS_RLAST  = 2'b00;
    chk("t5_rbust_pulse2", 64'(out_HLS_RBUST_READY), 64'd1);
    tick();
    chk("t5_rbust_clear2", 64'(out_HLS_RBUST_READY), 64'd0);
    auto_r = 1'b1;
    drain("t5", 32'h7000, 0, 2, 20);

    // Credit stall with consumer held off, then pop and issue in the same cycle
    in_USER_RREADY = 1'b0;
    c0             = iss_addr.size();
    push_req(32'h2000, 32'd64);
    repeat (60) tick();
    chk("t3_nchunks_stall", 64'(iss_addr.size() - c0), 64'd2);
    chk("t3_arvalid_stall", 64'(out_HLS_ARVALID), 64'd0);
    chk("t3_credit_zero", 64'(dut.credit_q), 64'd0);
    chk("t3_rvalid", 64'(out_USER_RVALID), 64'd1);
    in_USER_RREADY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_pop_data", 64'(out_USER_RDATA), 64'(32'h2000 + 32'(4 * i)));
      if (i == 15) chk("t3_arvalid_at15", 64'(out_HLS_ARVALID), 64'd0);
      tick();
    end
    chk("t3_arvalid_at16", 64'(out_HLS_ARVALID), 64'd1);
    chk("t3_araddr", 64'(out_HLS_ARADDR), 64'h2080);
    chk("t3_arlen", 64'(out_HLS_ARLEN), 64'd16);
    chk("t3_head", 64'(out_USER_RDATA), 64'h2040);
    tick();
    chk("t4_credit_both", 64'(dut.credit_q), 64'd1);
    drain("t3", 32'h2000, 17, 64, 300);
    chk("t3_nchunks", 64'(iss_addr.size() - c0), 64'd4);

    // Reset with 5 beats buffered mid-chunk
    in_USER_RREADY = 1'b0;
    k              = r_count;
    push_req(32'h8000, 32'd16);
    c0 = 0;
    while (r_count < k + 5 && c0 < 40) begin
      tick();
      c0++;
    end
    chk("t6_buffered", 64'(r_count - k), 64'd5);
    ARESET = 1'b1;
    flush  = 1'b1;
    tick();
    chk("t6_rvalid", 64'(out_USER_RVALID), 64'd0);
    chk("t6_arvalid", 64'(out_HLS_ARVALID), 64'd0);
    chk("t6_credit", 64'(dut.credit_q), 64'd32);
    chk("t6_arready", 64'(out_USER_ARREADY), 64'd1);
    ARESET = 1'b0;
    repeat (2) tick();
    chk("t6_rvalid_after", 64'(out_USER_RVALID), 64'd0);

    // Clock-enable freeze
    push_req(32'h3000, 32'd2);
    repeat (15) tick();
    chk("t6_pre_rvalid", 64'(out_USER_RVALID), 64'd1);
    chk("t6_pre_rdata", 64'(out_USER_RDATA), 64'h3000);
    chk("t6_pre_credit", 64'(dut.credit_q), 64'd30);
    c0              = iss_addr.size();
    ACLK_EN         = 1'b0;
    in_USER_RREADY  = 1'b1;
    in_USER_ARADDR  = 32'h9000;
    in_USER_ARLEN   = 32'd4;
    in_USER_ARVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_frz_rvalid", 64'(out_USER_RVALID), 64'd1);
      chk("t6_frz_rdata", 64'(out_USER_RDATA), 64'h3000);
      chk("t6_frz_rlast", 64'(out_USER_RLAST), 64'd0);
      chk("t6_frz_arvalid", 64'(out_HLS_ARVALID), 64'd0);
      chk("t6_frz_credit", 64'(dut.credit_q), 64'd30);
    end
    in_USER_ARVALID = 1'b0;
    ACLK_EN         = 1'b1;
    drain("t6", 32'h3000, 0, 2, 20);
    repeat (10) tick();
    chk("t6_no_extra_chunk", 64'(iss_addr.size()), 64'(c0));
    chk("t6_credit_end", 64'(dut.credit_q), 64'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
